// File: rtl/pmem_pkg.sv
// pmem_pkg: shared FSM state, error causes and width helpers for prog_mem_pipelined
package pmem_pkg;
  typedef enum logic {CLEAR, READY} state_t;
  localparam logic [1:0] ERR_NONE   = 2'd0;
  localparam logic [1:0] ERR_ALIGN  = 2'd1;
  localparam logic [1:0] ERR_RANGE  = 2'd2;
  localparam logic [1:0] ERR_PARITY = 2'd3;
  function automatic int off_w(input int data_w);
    return $clog2(data_w / 8);
  endfunction
  function automatic int idx_w(input int depth);
    return $clog2(depth);
  endfunction
endpackage

// File: rtl/pmem_rsp_pipe.sv
// pmem_rsp_pipe: RD_LAT-deep valid/data/err shift pipe; data holds while a stage is empty, rst flushes
module pmem_rsp_pipe #(
  parameter int DATA_W = 32,
  parameter int RD_LAT = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_err,
  output logic              out_valid,
  output logic [DATA_W-1:0] out_data,
  output logic              out_err
);
  logic [RD_LAT-1:0] v;
  logic [RD_LAT-1:0] e;
  logic [DATA_W-1:0] d [RD_LAT];
  always_ff @(posedge clk)
    if (rst) begin
      v <= '0;
      e <= '0;
      for (int i = 0; i < RD_LAT; i++) d[i] <= '0;
    end else begin
      v[0] <= in_valid;
      if (in_valid) begin
        d[0] <= in_data;
        e[0] <= in_err;
      end
      for (int i = 1; i < RD_LAT; i++) begin
        v[i] <= v[i-1];
        if (v[i-1]) begin
          d[i] <= d[i-1];
          e[i] <= e[i-1];
        end
      end
    end
  assign out_valid = v[RD_LAT-1];
  assign out_data  = d[RD_LAT-1];
  assign out_err   = e[RD_LAT-1];
endmodule

// File: rtl/prog_mem_pipelined.sv
// prog_mem_pipelined: word memory with byte-enable writes, address errors, reset clear sweep and RD_LAT response pipe
// Optional PMEM_PARITY_EN adds per-byte even parity and a parity_flip test input.
module prog_mem_pipelined
  import pmem_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 256,
  parameter int ADDR_W = 32,
  parameter int RD_LAT = 1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                req_valid,
  output logic                req_ready,
  input  logic                req_write,
  input  logic [ADDR_W-1:0]   address,
  input  logic [DATA_W-1:0]   write_data,
  input  logic [DATA_W/8-1:0] byte_en,
`ifdef PMEM_PARITY_EN
  input  logic                parity_flip,
`endif
  output logic                rsp_valid,
  output logic [DATA_W-1:0]   read_data,
  output logic                rsp_err,
  output logic                init_done
);
  localparam int NB    = DATA_W / 8;
  localparam int OFF_W = off_w(DATA_W);
  localparam int IDX_W = idx_w(DEPTH);
  state_t state;
  logic [IDX_W-1:0] clr_idx;
  logic [IDX_W-1:0] idx;
  logic [DATA_W-1:0] mem [DEPTH];
  logic [DATA_W-1:0] rd_word;
  logic [1:0] cause;
  logic accept, we, clr_we, par_err;
  assign idx     = address[OFF_W +: IDX_W];
  assign rd_word = mem[idx];
  assign accept  = req_valid && req_ready;
  assign cause   = |address[OFF_W-1:0] ? ERR_ALIGN :
                   |(address >> (OFF_W + IDX_W)) ? ERR_RANGE :
                   (par_err && !req_write) ? ERR_PARITY : ERR_NONE;
  assign we      = accept && req_write && cause == ERR_NONE && !rst;
  assign clr_we  = state == CLEAR && !rst;
  always_ff @(posedge clk)
    if (rst) begin
      state     <= CLEAR;
      clr_idx   <= '0;
      req_ready <= 1'b0;
      init_done <= 1'b0;
    end else if (state == CLEAR) begin
      clr_idx <= clr_idx + IDX_W'(1);
      if (clr_idx == IDX_W'(DEPTH - 1)) begin
        state     <= READY;
        req_ready <= 1'b1;
        init_done <= 1'b1;
      end
    end
  always_ff @(posedge clk)
    if (clr_we) mem[clr_idx] <= '0;
    else if (we)
      for (int b = 0; b < NB; b++)
        if (byte_en[b]) mem[idx][b*8 +: 8] <= write_data[b*8 +: 8];
`ifdef PMEM_PARITY_EN
  logic [NB-1:0] par [DEPTH];
  always_ff @(posedge clk)
    if (clr_we) par[clr_idx] <= '0;
    else if (we)
      for (int b = 0; b < NB; b++)
        if (byte_en[b]) par[idx][b] <= ^write_data[b*8 +: 8] ^ parity_flip;
  always_comb begin
    par_err = 1'b0;
    for (int b = 0; b < NB; b++) par_err = par_err | ((^rd_word[b*8 +: 8]) != par[idx][b]);
  end
`else
  assign par_err = 1'b0;
`endif
  // parity errors still return the stored word; address errors and writes return zero
  pmem_rsp_pipe #(.DATA_W(DATA_W), .RD_LAT(RD_LAT)) u_pipe (
    .clk      (clk),
    .rst      (rst),
    .in_valid (accept),
    .in_data  ((!req_write && (cause == ERR_NONE || cause == ERR_PARITY)) ? rd_word : '0),
    .in_err   (cause != ERR_NONE),
    .out_valid(rsp_valid),
    .out_data (read_data),
    .out_err  (rsp_err)
  );
endmodule

// File: tb/tb_prog_mem_pipelined.sv
// tb_prog_mem_pipelined: scoreboard bench driving RD_LAT=1 and RD_LAT=2 copies with shared directed stimulus
module tb_prog_mem_pipelined;
  typedef struct {
    logic [31:0] d;
    logic        e;
    int          due;
  } exp_t;
  logic clk = 1'b0, rst = 1'b1, req_valid = 1'b0, req_write = 1'b0, rst_q;
  logic [31:0] address = '0, write_data = '0;
  logic [3:0] byte_en = '0;
  logic rdy1, rdy2, v1, v2, e1, e2, done1, done2;
  logic [31:0] d1, d2, last1 = '0, last2 = '0;
  exp_t q1[$], q2[$];
  int checks = 0, errors = 0, cyc = 0;

  prog_mem_pipelined #(.DATA_W(32), .DEPTH(64), .ADDR_W(32), .RD_LAT(1)) dut1 (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(rdy1), .req_write(req_write),
    .address(address), .write_data(write_data), .byte_en(byte_en),
    .rsp_valid(v1), .read_data(d1), .rsp_err(e1), .init_done(done1));
  prog_mem_pipelined #(.DATA_W(32), .DEPTH(64), .ADDR_W(32), .RD_LAT(2)) dut2 (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(rdy2), .req_write(req_write),
    .address(address), .write_data(write_data), .byte_en(byte_en),
    .rsp_valid(v2), .read_data(d2), .rsp_err(e2), .init_done(done2));

  always #5 clk = ~clk;
  always @(posedge clk) begin
    cyc   <= cyc + 1;
    rst_q <= rst;
  end

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %h want %h", nm, got, want);
    end
  endtask

  task automatic mon(input int w, input logic v, input logic [31:0] d, input logic e);
    exp_t x;
    string n = (w == 0) ? "lat1" : "lat2";
    int sz = (w == 0) ? q1.size() : q2.size();
    if (rst_q) begin
      chk({n, " reset rsp_valid"}, 32'(v), 32'd0);
      chk({n, " reset read_data"}, d, 32'd0);
      chk({n, " reset rsp_err"}, 32'(e), 32'd0);
      if (w == 0) begin last1 = '0; q1.delete(); end
      else begin last2 = '0; q2.delete(); end
    end else if (v) begin
      checks++;
      if (sz == 0) begin
        errors++;
        $display("FAIL %s unexpected rsp_valid: got 1 want 0", n);
      end else begin
        if (w == 0) x = q1.pop_front();
        else x = q2.pop_front();
        chk({n, " read_data"}, d, x.d);
        chk({n, " rsp_err"}, 32'(e), 32'(x.e));
        chk({n, " latency cycle"}, 32'(cyc), 32'(x.due));
      end
      if (w == 0) last1 = d;
      else last2 = d;
    end else begin
      chk({n, " read_data hold"}, d, (w == 0) ? last1 : last2);
      if (sz > 0) chk({n, " response overdue"}, 32'((w == 0 ? q1[0].due : q2[0].due) < cyc), 32'd0);
    end
  endtask

  always @(negedge clk) begin
    mon(0, v1, d1, e1);
    mon(1, v2, d2, e2);
  end

  task automatic issue(input logic wr, input logic [31:0] a, input logic [31:0] wd, input logic [3:0] be,
                       input logic [31:0] ed, input logic ee, input bit push2);
    exp_t x;
    req_valid = 1'b1; req_write = wr; address = a; write_data = wd; byte_en = be;
    chk("req_ready at issue", 32'(rdy1 & rdy2), 32'd1);
    x.d = ed; x.e = ee; x.due = cyc + 1;
    q1.push_back(x);
    if (push2) begin
      x.due = cyc + 2;
      q2.push_back(x);
    end
    @(posedge clk); #1;
    req_valid = 1'b0;
  endtask

  task automatic wait_init();
    int n = 0;
    while (!rdy1 && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
    chk("cycles to ready", 32'(n), 32'd64);
    chk("ready copies agree", 32'(rdy2), 32'd1);
    chk("init_done lat1", 32'(done1), 32'd1);
    chk("init_done lat2", 32'(done2), 32'd1);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1);
  end

  initial begin
    repeat (3) @(posedge clk);
    #1;
    chk("req_ready in reset", 32'(rdy1 | rdy2), 32'd0);
    chk("init_done in reset", 32'(done1 | done2), 32'd0);
    rst = 1'b0;
    wait_init();
    issue(0, 32'h10, 0, 4'h0, 32'h0, 0, 1);
    issue(1, 32'h4, 32'h12345678, 4'hF, 32'h0, 0, 1);
    issue(0, 32'h4, 0, 4'h0, 32'h12345678, 0, 1);
    issue(1, 32'h4, 32'hAABBCCDD, 4'b0010, 32'h0, 0, 1);
    issue(0, 32'h4, 0, 4'h0, 32'h1234CC78, 0, 1);
    issue(0, 32'h6, 0, 4'h0, 32'h0, 1, 1);
    issue(1, 32'h100, 32'h87654321, 4'hF, 32'h0, 1, 1);
    issue(0, 32'h0, 0, 4'h0, 32'h0, 0, 1);
    issue(1, 32'h80000004, 32'hDEADBEEF, 4'hF, 32'h0, 1, 1);
    issue(0, 32'h4, 0, 4'h0, 32'h1234CC78, 0, 1);
    issue(1, 32'h0, 32'h11, 4'hF, 32'h0, 0, 1);
    issue(1, 32'h4, 32'h22, 4'hF, 32'h0, 0, 1);
    issue(1, 32'h8, 32'h33, 4'hF, 32'h0, 0, 1);
    issue(1, 32'hC, 32'h44, 4'hF, 32'h0, 0, 1);
    issue(1, 32'h8, 32'hFFFFFFFF, 4'h0, 32'h0, 0, 1);
    issue(0, 32'h0, 0, 4'h0, 32'h11, 0, 1);
    issue(0, 32'h4, 0, 4'h0, 32'h22, 0, 1);
    issue(0, 32'h8, 0, 4'h0, 32'h33, 0, 1);
    issue(0, 32'hC, 0, 4'h0, 32'h44, 0, 1);
    issue(0, 32'h6, 0, 4'h0, 32'h0, 1, 1);
    repeat (4) @(posedge clk);
    #1;
    // the RD_LAT=1 copy answers before the reset edge; the RD_LAT=2 copy must drop it
    issue(0, 32'h4, 0, 4'h0, 32'h22, 0, 0);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    wait_init();
    issue(0, 32'h4, 0, 4'h0, 32'h0, 0, 1);
    issue(0, 32'hFC, 0, 4'h0, 32'h0, 0, 1);
    repeat (5) @(posedge clk);
    #1;
    chk("lat1 queue drained", 32'(q1.size()), 32'd0);
    chk("lat2 queue drained", 32'(q2.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/prog_mem_pipelined.md
Name: prog_mem_pipelined

Overview:
- Parametrised, word-organised program/data memory with a valid/ready request port and an in-order response pipeline.
- Next generation of the single-cycle program memory: configurable width, depth and read latency.
- Adds byte-enable writes, address error detection, and a reset-time clear sweep.
- Sits between the fetch/load-store logic and the CPU datapath.

Parameters:
- DATA_W, 32, word width in bits; must be a multiple of 8 and at least 16.
- DEPTH, 256, number of words; must be a power of two.
- ADDR_W, 32, byte-address width.
- RD_LAT, 1, cycles from request acceptance to response; legal values are 1 or 2.

Ports:
- clk  in  1  clock; all logic on the rising edge.
- rst  in  1  synchronous, active-high reset.
- req_valid  in  1  request present.
- req_ready  out  1  block can accept a request.
- req_write  in  1  1 = write, 0 = read.
- address  in  ADDR_W  byte address.
- write_data  in  DATA_W  write data.
- byte_en  in  DATA_W/8  per-byte write enable; ignored on reads.
- rsp_valid  out  1  response strobe.
- read_data  out  DATA_W  read result.
- rsp_err  out  1  error flag qualifying rsp_valid.
- init_done  out  1  high once the clear sweep has finished.

Behaviour:
- Reset values: req_ready=0, rsp_valid=0, read_data=0, rsp_err=0, init_done=0. All pipeline stages are invalidated.
- FSM states:
  - CLEAR (entered on rst): writes zero to word clr_idx, one word per cycle, clr_idx counting 0..DEPTH-1.
  - CLEAR -> READY after word DEPTH-1 is written. Exactly DEPTH cycles after rst deasserts.
  - In READY: init_done=1 and req_ready=1 constantly. There is no response backpressure.
- Accept on req_valid && req_ready. Throughput is one request per cycle.
- Word index = address[log2(DATA_W/8) +: log2(DEPTH)].
- Errors:
  - Misaligned: any of address[log2(DATA_W/8)-1:0] nonzero.
  - Out of range: any address bit at or above log2(DATA_W/8)+log2(DEPTH) set.
  - An errored request performs no memory write. Its response has rsp_err=1 and read_data=0.
- Write:
  - Enabled bytes are updated at the acceptance edge; disabled bytes are kept. byte_en=0 is a legal no-op.
  - A response is still issued for every write: rsp_err as computed, read_data=0.
- Read: the array is sampled at the acceptance edge. read_data and rsp_valid appear RD_LAT cycles after acceptance.
- Ordering: responses are strictly in request order. rsp_valid is high for exactly one cycle per accepted request.
- Read-after-write: a read accepted in any cycle after a write to the same word returns the written data. Same-cycle hazards cannot occur because there is only one port.
- read_data holds its last value while rsp_valid=0. It updates only on response cycles.
- rst asserted mid-operation: in-flight responses are discarded (rsp_valid never pulses for them). A new clear sweep starts on the next cycle, and contents are zeroed again.
- Requests presented while req_ready=0 are ignored and never queued.

Optional Feature:
- Macro: PMEM_PARITY_EN.
- When defined:
  - One even-parity bit is stored per byte and written alongside the data.
  - The clear sweep writes parity 0.
  - On a read, recomputed parity is compared with stored parity. Any mismatch sets rsp_err=1 while still returning the stored data.
  - A test-only input `parity_flip` (1 bit) inverts the stored parity of the bytes written on that cycle.
- When undefined: no parity storage, no `parity_flip` port, and rsp_err reports address errors only.

Decomposition:
- Package `pmem_pkg` holds:
  - FSM state enum (CLEAR, READY).
  - Localparam helpers for byte-offset width and index width.
  - Error-cause constants.
- One natural sub-module, `pmem_rsp_pipe`: an RD_LAT-deep valid/data/err shift pipeline with synchronous flush on rst.
- The array, FSM and address decode stay in the top module.

Test Plan (DATA_W=32, DEPTH=64, RD_LAT=1 unless noted):
- Init sweep: deassert rst, then read 0x10 once req_ready=1 -> init_done rises exactly 64 cycles after reset release; the read returns 0x00000000 with rsp_err=0.
- Write/read: write 0x12345678 to 0x4 with byte_en=4'hF, then read 0x4 -> one cycle after the read is accepted, rsp_valid=1 and read_data=0x12345678.
- Byte enable: after the previous case, write 0xAABBCCDD to 0x4 with byte_en=4'b0010, then read -> 0x1234CC78.
- Errors:
  - Read 0x6 -> rsp_err=1, read_data=0.
  - Write 0x87654321 to 0x100 (word 64) -> rsp_err=1.
  - A subsequent read of 0x0 -> 0x00000000, rsp_err=0.
- Back-to-back with RD_LAT=2: five consecutive reads of 0x0, 0x4, 0x8, 0xC, 0x6 after seeding words 0..3 with 0x11, 0x22, 0x33, 0x44 -> five consecutive rsp_valid pulses in order, the last one with rsp_err=1.
- Reset mid-flight: assert rst in the cycle after a read is accepted -> no rsp_valid for that read; req_ready is low for 64 cycles; a read of 0x4 afterwards returns 0.
